dma_ctrl_regs: RTL and testbench

DMA_CTRL_REGS -- requirements
Module: dma_ctrl_regs

---
 rtl/dma_ctrl_regs.sv | 212 +++++++++++++++++++++
 tb/tb_dma_ctrl_regs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl_regs.sv
// AXI4-Lite register block for a DMA engine: CTRL/SRC/DST/LEN/STATUS plus done IRQ.
// Write response 1 cycle after commit, read data 1 cycle after AR; B/R held until BREADY/RREADY.
module dma_ctrl_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        DMAEN,
    output logic [31:0] DMASRC,
    output logic [31:0] DMADST,
    output logic [31:0] DMALEN,
    input  logic        dma_done,
    output logic        DMA_irq
);

    typedef enum logic [1:0] {WS_IDLE, WS_GOT_AW, WS_GOT_W, WS_RESP} ws_t;
    typedef enum logic {RS_IDLE, RS_DATA} rs_t;

    ws_t         ws_q, ws_d;
    rs_t         rs_q, rs_d;
    logic        en_q, ie_q, done_q, irq_q;
    logic [31:0] src_q, dst_q, len_q;
    logic [2:0]  aw_off_q;
    logic [31:0] wdat_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  c_off;
    logic [31:0] c_dat;
    logic [3:0]  c_strb;
    logic [1:0]  ctrl_b;
    logic        en_w, ie_w, done_w;
    logic [31:0] src_w, dst_w, len_w;
    logic [1:0]  wr_resp;
    logic [31:0] rd_dat;
    logic [1:0]  rd_resp;
    logic        unused_bits;

    assign unused_bits = ^{AWADDR[31:5], AWADDR[1:0], ARADDR[31:5], ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = dat[b*8 +: 8];
        end
        return r;
    endfunction

    assign AWREADY = (ws_q == WS_IDLE) || (ws_q == WS_GOT_W);
    assign WREADY  = (ws_q == WS_IDLE) || (ws_q == WS_GOT_AW);
    assign BVALID  = (ws_q == WS_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = (rs_q == RS_IDLE);
    assign RVALID  = (rs_q == RS_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign DMAEN   = en_q;
    assign DMASRC  = src_q;
    assign DMADST  = dst_q;
    assign DMALEN  = len_q;
    assign DMA_irq = irq_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The half captured earlier comes from the latch, the other half is live this cycle.
    assign c_off  = (ws_q == WS_GOT_AW) ? aw_off_q : AWADDR[4:2];
    assign c_dat  = (ws_q == WS_GOT_W)  ? wdat_q   : WDATA;
    assign c_strb = (ws_q == WS_GOT_W)  ? wstrb_q  : WSTRB;
    assign ctrl_b = c_strb[0] ? c_dat[1:0] : {ie_q, en_q};

    always_comb begin
        ws_d   = ws_q;
        commit = 1'b0;
        case (ws_q)
            WS_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    ws_d   = WS_RESP;
                end else if (aw_hs) begin
                    ws_d = WS_GOT_AW;
                end else if (w_hs) begin
                    ws_d = WS_GOT_W;
                end
            end
            WS_GOT_AW: if (w_hs) begin
                commit = 1'b1;
                ws_d   = WS_RESP;
            end
            WS_GOT_W: if (aw_hs) begin
                commit = 1'b1;
                ws_d   = WS_RESP;
            end
            WS_RESP: if (BREADY) ws_d = WS_IDLE;
            default: ws_d = WS_IDLE;
        endcase
    end

    always_comb begin
        en_w    = en_q;
        ie_w    = ie_q;
        done_w  = done_q;
        src_w   = src_q;
        dst_w   = dst_q;
        len_w   = len_q;
        wr_resp = 2'b00;
        if (commit) begin
            case (c_off)
                3'd0: begin
                    ie_w = ctrl_b[1];
                    if (ctrl_b[0] && (len_q == 32'd0)) begin
                        en_w    = 1'b0;
                        wr_resp = 2'b10;
                    end else begin
                        en_w = ctrl_b[0];
                    end
                end
                3'd1: if (!en_q) src_w = merge(src_q, c_dat, c_strb);
                3'd2: if (!en_q) dst_w = merge(dst_q, c_dat, c_strb);
                3'd3: if (!en_q) len_w = merge(len_q, c_dat, c_strb);
                3'd4: if (c_dat[1] && c_strb[0]) done_w = 1'b0;
                default: wr_resp = 2'b10;
            endcase
        end
        // Engine completion overrides any coincident software write.
        if (dma_done) en_w = 1'b0;
        if (dma_done && en_q) done_w = 1'b1;
    end

    always_comb begin
        rd_dat  = 32'd0;
        rd_resp = 2'b00;
        case (ARADDR[4:2])
            3'd0:    rd_dat = {30'd0, ie_q, en_q};
            3'd1:    rd_dat = src_q;
            3'd2:    rd_dat = dst_q;
            3'd3:    rd_dat = len_q;
            3'd4:    rd_dat = {30'd0, done_q, en_q};
            default: rd_resp = 2'b10;
        endcase
    end

    always_comb begin
        rs_d = rs_q;
        case (rs_q)
            RS_IDLE: if (ARVALID) rs_d = RS_DATA;
            RS_DATA: if (RREADY)  rs_d = RS_IDLE;
            default: rs_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ws_q     <= WS_IDLE;
            rs_q     <= RS_IDLE;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            len_q    <= 32'd0;
            aw_off_q <= 3'd0;
            wdat_q   <= 32'd0;
            wstrb_q  <= 4'd0;
            bresp_q  <= 2'b00;
            rdata_q  <= 32'd0;
            rresp_q  <= 2'b00;
        end else begin
            ws_q   <= ws_d;
            rs_q   <= rs_d;
            en_q   <= en_w;
            ie_q   <= ie_w;
            done_q <= done_w;
            src_q  <= src_w;
            dst_q  <= dst_w;
            len_q  <= len_w;
            irq_q  <= done_q & ie_q;
            if (ws_q == WS_IDLE && aw_hs) aw_off_q <= AWADDR[4:2];
            if (ws_q == WS_IDLE && w_hs) begin
                wdat_q  <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (commit) bresp_q <= wr_resp;
            if (ar_hs) begin
                rdata_q <= rd_dat;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// Directed bench for dma_ctrl_regs; write/read responses are checked against a scoreboard queue.
module tb_dma_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        DMAEN;
    logic [31:0] DMASRC, DMADST, DMALEN;
    logic        dma_done = 1'b0;
    logic        DMA_irq;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    dma_ctrl_regs dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
        .dma_done(dma_done), .DMA_irq(DMA_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_b();
        logic [1:0] e;
        bit seen;
        seen = 1'b0;
        BREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (BVALID) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        e = bq.pop_front();
        if (seen) chk("bresp", 32'(BRESP), 32'(e));
        else      chk("bvalid_timeout", 32'(BVALID), 32'd1);
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r);
        bit aw_done, w_done, aw_hit, w_hit;
        aw_done = 1'b0;
        w_done  = 1'b0;
        bq.push_back(r);
        @(negedge clk);
        AWADDR = a; AWVALID = 1'b1;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hit = AWVALID && AWREADY;
            w_hit  = WVALID && WREADY;
            @(negedge clk);
            if (aw_hit) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hit)  begin WVALID = 1'b0;  w_done = 1'b1;  end
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        wait_b();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        logic [33:0] e;
        bit hit, seen;
        seen = 1'b0;
        rq.push_back({r, d});
        @(negedge clk);
        ARADDR = a; ARVALID = 1'b1;
        for (int i = 0; i < 20 && ARVALID; i++) begin
            hit = ARVALID && ARREADY;
            @(negedge clk);
            if (hit) ARVALID = 1'b0;
        end
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (RVALID) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        e = rq.pop_front();
        if (seen) begin
            chk("rdata", RDATA, e[31:0]);
            chk("rresp", 32'(RRESP), 32'(e[33:32]));
        end else begin
            chk("rvalid_timeout", 32'(RVALID), 32'd1);
        end
        @(negedge clk);
        RREADY = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_wready",  32'(WREADY),  32'd1);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_bvalid",  32'(BVALID),  32'd0);
        chk("rst_rvalid",  32'(RVALID),  32'd0);
        chk("rst_dmaen",   32'(DMAEN),   32'd0);
        chk("rst_dmasrc",  DMASRC,       32'd0);
        chk("rst_irq",     32'(DMA_irq), 32'd0);

        // basic programming, AW/W together
        wr(32'h04, 32'h1000, 4'hF, 2'b00);
        wr(32'h08, 32'h2000, 4'hF, 2'b00);
        wr(32'h0C, 32'h40,   4'hF, 2'b00);
        wr(32'h00, 32'h3,    4'hF, 2'b00);
        chk("prog_src", DMASRC, 32'h1000);
        chk("prog_dst", DMADST, 32'h2000);
        chk("prog_len", DMALEN, 32'h40);
        chk("prog_en",  32'(DMAEN), 32'd1);
        rd(32'h00, 32'h3, 2'b00);
        rd(32'h10, 32'h1, 2'b00);

        // address writes discarded while running
        wr(32'h08, 32'h5555, 4'hF, 2'b00);
        chk("dst_locked", DMADST, 32'h2000);

        // completion and interrupt
        @(negedge clk); dma_done = 1'b1;
        @(negedge clk); dma_done = 1'b0;
        chk("done_en_clr", 32'(DMAEN), 32'd0);
        chk("irq_lag", 32'(DMA_irq), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(DMA_irq), 32'd1);
        rd(32'h10, 32'h2, 2'b00);
        wr(32'h10, 32'h2, 4'h1, 2'b00);
        chk("irq_clr", 32'(DMA_irq), 32'd0);
        rd(32'h10, 32'h0, 2'b00);

        // dma_done coincident with DONE W1C: set wins
        wr(32'h00, 32'h3, 4'hF, 2'b00);
        bq.push_back(2'b00);
        @(negedge clk);
        AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h2; WSTRB = 4'h1; WVALID = 1'b1;
        dma_done = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0; dma_done = 1'b0;
        wait_b();
        chk("coinc_en", 32'(DMAEN), 32'd0);
        rd(32'h10, 32'h2, 2'b00);
        wr(32'h10, 32'h2, 4'h1, 2'b00);
        @(negedge clk); dma_done = 1'b1;
        @(negedge clk); dma_done = 1'b0;
        rd(32'h10, 32'h0, 2'b00);

        // W two cycles ahead of AW, partial strobes, B held
        wr(32'h04, 32'h0, 4'hF, 2'b00);
        @(negedge clk);
        WDATA = 32'hAABBCCDD; WSTRB = 4'b0011; WVALID = 1'b1;
        @(negedge clk);
        WVALID = 1'b0;
        chk("gotw_wready",  32'(WREADY),  32'd0);
        chk("gotw_awready", 32'(AWREADY), 32'd1);
        @(negedge clk);
        AWADDR = 32'h04; AWVALID = 1'b1;
        bq.push_back(2'b00);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bvalid_hold", 32'(BVALID),  32'd1);
            chk("bresp_hold",  32'(BRESP),   32'd0);
            chk("resp_awrdy",  32'(AWREADY), 32'd0);
            @(negedge clk);
        end
        wait_b();
        chk("src_strb", DMASRC, 32'h0000CCDD);

        // LEN==0 rejects enable; unmapped accesses; upper address bits ignored
        wr(32'h0C, 32'h0, 4'hF, 2'b00);
        wr(32'h00, 32'h1, 4'hF, 2'b10);
        chk("len0_en", 32'(DMAEN), 32'd0);
        wr(32'h00, 32'h3, 4'hF, 2'b10);
        rd(32'h00, 32'h2, 2'b00);
        rd(32'h18, 32'h0, 2'b10);
        wr(32'h14, 32'hFFFF, 4'hF, 2'b10);
        rd(32'hFFFF_FFE4, 32'h0000CCDD, 2'b00);

        // reset in WS_GOT_AW and RS_DATA
        @(negedge clk);
        AWADDR = 32'h08; AWVALID = 1'b1; ARADDR = 32'h04; ARVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("gotaw_wready",  32'(WREADY),  32'd1);
        chk("gotaw_awready", 32'(AWREADY), 32'd0);
        chk("rvalid_up", 32'(RVALID), 32'd1);
        chk("rdata_cap", RDATA, 32'h0000CCDD);
        @(negedge clk);
        chk("rvalid_hold", 32'(RVALID), 32'd1);
        chk("rdata_hold",  RDATA, 32'h0000CCDD);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(BVALID), 32'd0);
        chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
        chk("mid_rst_src",    DMASRC, 32'd0);
        chk("mid_rst_awrdy",  32'(AWREADY), 32'd1);
        rst = 1'b1;
        rd(32'h04, 32'h0, 2'b00);
        rd(32'h00, 32'h0, 2'b00);
        wr(32'h08, 32'h77, 4'hF, 2'b00);
        chk("post_rst_dst", DMADST, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
